// File: rtl/sys_cfg_pkg.sv
// Shared configuration constants for the system register file.
// Covers entry addresses, reset values and the UART configuration field layout.
package sys_cfg_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned ADDR_WIDTH_DEF = 4;

  localparam int unsigned ADDR_ALU_A     = 0;
  localparam int unsigned ADDR_ALU_B     = 1;
  localparam int unsigned ADDR_UART_CFG  = 2;
  localparam int unsigned ADDR_DIV_RATIO = 3;

  localparam int unsigned PAR_EN       = 0;
  localparam int unsigned PAR_TYP      = 1;
  localparam int unsigned PRESCALE_LSB = 2;
  localparam int unsigned PRESCALE_MSB = 7;

  // Assembles a UART configuration byte from its individual fields.
  function automatic logic [7:0] pack_uart_cfg(input logic [5:0] prescale,
                                               input logic       par_typ,
                                               input logic       par_en);
    logic [7:0] v;
    v = '0;
    v[PRESCALE_MSB:PRESCALE_LSB] = prescale;
    v[PAR_TYP] = par_typ;
    v[PAR_EN]  = par_en;
    return v;
  endfunction

  localparam logic [7:0] REG2_RST = pack_uart_cfg(6'd32, 1'b0, 1'b1);
  localparam logic [7:0] REG3_RST = 8'h20;

endpackage

// File: rtl/sys_reg_file.sv
// Configuration/scratch register file with a registered read port and a one-cycle valid strobe.
// Entries 0..3 are also exported continuously for the ALU, UART and clock divider.
module sys_reg_file #(
  parameter int unsigned DATA_WIDTH = sys_cfg_pkg::DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = sys_cfg_pkg::ADDR_WIDTH_DEF,
  parameter logic [DATA_WIDTH-1:0] REG2_RST = DATA_WIDTH'(sys_cfg_pkg::REG2_RST),
  parameter logic [DATA_WIDTH-1:0] REG3_RST = DATA_WIDTH'(sys_cfg_pkg::REG3_RST)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  WrEn,
  input  logic                  RdEn,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [DATA_WIDTH-1:0] WrData,
  output logic [DATA_WIDTH-1:0] RdData,
  output logic                  RdData_VLD,
  output logic [DATA_WIDTH-1:0] REG0,
  output logic [DATA_WIDTH-1:0] REG1,
  output logic [DATA_WIDTH-1:0] REG2,
  output logic [DATA_WIDTH-1:0] REG3
);
  import sys_cfg_pkg::*;

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_vld;

  function automatic logic [DATA_WIDTH-1:0] entry_rst(input int unsigned idx);
    if (idx == ADDR_UART_CFG)  return REG2_RST;
    if (idx == ADDR_DIV_RATIO) return REG3_RST;
    return '0;
  endfunction

  // A write takes priority over a read in the same cycle; the read is dropped.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= entry_rst(i);
      end
      r_rd_data <= '0;
      r_rd_vld  <= 1'b0;
    end else begin
      r_rd_vld <= 1'b0;
      if (WrEn) begin
        r_mem[Address] <= WrData;
      end else if (RdEn) begin
        r_rd_data <= r_mem[Address];
        r_rd_vld  <= 1'b1;
      end
    end
  end

  assign RdData     = r_rd_data;
  assign RdData_VLD = r_rd_vld;
  assign REG0       = r_mem[ADDR_WIDTH'(ADDR_ALU_A)];
  assign REG1       = r_mem[ADDR_WIDTH'(ADDR_ALU_B)];
  assign REG2       = r_mem[ADDR_WIDTH'(ADDR_UART_CFG)];
  assign REG3       = r_mem[ADDR_WIDTH'(ADDR_DIV_RATIO)];

endmodule
